// File: rtl/ibex_mem_arbiter.sv
// Purpose: two-to-one arbiter sharing one req/gnt/rvalid memory port between instr fetch and data.
// Latency: grant and response paths are combinational (zero cycles); ID FIFO routes in-order responses.
// Backpressure: mem_gnt_i stalls the winner with its request locked; a full ID FIFO masks mem_req_o.
// Optional feature: define ARB_PERF_CNT_EN to build the saturating performance counters.
module ibex_mem_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          RoundRobin     = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,

    output logic        busy_o,
    output logic [31:0] perf_instr_gnt_o,
    output logic [31:0] perf_data_gnt_o,
    output logic [31:0] perf_stall_o
);

    localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CW = $clog2(MaxOutstanding + 1);

    // Source IDs stored in the FIFO and used for the priority/lock registers.
    localparam logic SRC_INSTR = 1'b0;
    localparam logic SRC_DATA  = 1'b1;

    logic [MaxOutstanding-1:0] id_q;
    logic [PW-1:0]             wptr_q;
    logic [PW-1:0]             rptr_q;
    logic [CW-1:0]             count_q;
    logic                      prio_q;
    logic                      lock_q;
    logic                      lock_src_q;

    logic any_req;
    logic full;
    logic winner;
    logic grant;
    logic pop;
    logic head;

    // Pointers wrap at MaxOutstanding, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(MaxOutstanding - 1)) ? '0 : p + PW'(1);
    endfunction

    assign any_req = instr_req_i | data_req_i;
    assign full    = (count_q == CW'(MaxOutstanding));

    // Winner selection: a stalled request keeps ownership until it is granted.
    always_comb begin
        winner = prio_q;
        if (lock_q) begin
            winner = lock_src_q;
        end else if (data_req_i && !instr_req_i) begin
            winner = SRC_DATA;
        end else if (instr_req_i && !data_req_i) begin
            winner = SRC_INSTR;
        end else if (instr_req_i && data_req_i) begin
            winner = RoundRobin ? prio_q : SRC_DATA;
        end
    end

    assign mem_req_o   = any_req & ~full;
    assign grant       = mem_req_o & mem_gnt_i;
    assign mem_addr_o  = (winner == SRC_DATA) ? data_addr_i  : instr_addr_i;
    assign mem_we_o    = (winner == SRC_DATA) ? data_we_i    : 1'b0;
    assign mem_be_o    = (winner == SRC_DATA) ? data_be_i    : 4'hF;
    assign mem_wdata_o = (winner == SRC_DATA) ? data_wdata_i : 32'h0;

    assign instr_gnt_o = grant & (winner == SRC_INSTR);
    assign data_gnt_o  = grant & (winner == SRC_DATA);

    // A response with nothing outstanding is a downstream protocol error and is dropped.
    assign head           = id_q[rptr_q];
    assign pop            = mem_rvalid_i & (count_q != '0);
    assign instr_rvalid_o = pop & (head == SRC_INSTR);
    assign data_rvalid_o  = pop & (head == SRC_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = mem_err_i;
    assign data_err_o     = mem_err_i;
    assign busy_o         = (count_q != '0);

    // Outstanding-ID FIFO: push the winner on grant, pop the head on response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (grant) begin
                id_q[wptr_q] <= winner;
                wptr_q       <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            if (grant && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !grant) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Lock holds the downstream address stable while stalled; priority flips to the loser on grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q     <= SRC_DATA;
            lock_q     <= 1'b0;
            lock_src_q <= SRC_INSTR;
        end else if (grant) begin
            prio_q <= ~winner;
            lock_q <= 1'b0;
        end else if (mem_req_o) begin
            lock_q     <= 1'b1;
            lock_src_q <= winner;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_instr_q;
    logic [31:0] perf_data_q;
    logic [31:0] perf_stall_q;
    logic        stall;

    assign stall = any_req & ~grant;

    // Saturating event counters: grants per port and request-pending-but-not-granted cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_instr_q <= '0;
            perf_data_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (instr_gnt_o && (perf_instr_q != '1)) begin
                perf_instr_q <= perf_instr_q + 32'd1;
            end
            if (data_gnt_o && (perf_data_q != '1)) begin
                perf_data_q <= perf_data_q + 32'd1;
            end
            if (stall && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_instr_gnt_o = perf_instr_q;
    assign perf_data_gnt_o  = perf_data_q;
    assign perf_stall_o     = perf_stall_q;
`else
    assign perf_instr_gnt_o = 32'h0;
    assign perf_data_gnt_o  = 32'h0;
    assign perf_stall_o     = 32'h0;
`endif

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Purpose: self-checking bench for ibex_mem_arbiter against a queue-based reference model.
// Latency: inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Backpressure: mem_gnt_i/mem_rvalid_i are driven directly (directed patterns and random).
module tb_ibex_mem_arbiter;

    localparam int unsigned MAXO = 2;
    localparam bit          RR   = 1'b1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        instr_req, data_req, data_we, mem_gnt, mem_rvalid, mem_err;
    logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;
    logic [3:0]  data_be;

    logic        instr_gnt, instr_rvalid, instr_err, data_gnt, data_rvalid, data_err;
    logic        mem_req, mem_we, busy;
    logic [31:0] instr_rdata, data_rdata, mem_addr, mem_wdata, perf_i, perf_d, perf_s;
    logic [3:0]  mem_be;

    logic        instr_gnt_b, instr_rvalid_b, instr_err_b, data_gnt_b, data_rvalid_b, data_err_b;
    logic        mem_req_b, mem_we_b, busy_b;
    logic [31:0] instr_rdata_b, data_rdata_b, mem_addr_b, mem_wdata_b, perf_i_b, perf_d_b, perf_s_b;
    logic [3:0]  mem_be_b;

    ibex_mem_arbiter #(.MaxOutstanding(MAXO), .RoundRobin(RR)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid),
        .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
        .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
        .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_rdata_o(data_rdata), .data_err_o(data_err),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_err_i(mem_err), .busy_o(busy),
        .perf_instr_gnt_o(perf_i), .perf_data_gnt_o(perf_d), .perf_stall_o(perf_s)
    );

    // Fixed-priority variant with a non-power-of-two FIFO depth.
    ibex_mem_arbiter #(.MaxOutstanding(3), .RoundRobin(1'b0)) dut_fixed (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(instr_req), .instr_gnt_o(instr_gnt_b), .instr_rvalid_o(instr_rvalid_b),
        .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata_b), .instr_err_o(instr_err_b),
        .data_req_i(data_req), .data_gnt_o(data_gnt_b), .data_rvalid_o(data_rvalid_b),
        .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_rdata_o(data_rdata_b), .data_err_o(data_err_b),
        .mem_req_o(mem_req_b), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_we_o(mem_we_b), .mem_be_o(mem_be_b), .mem_addr_o(mem_addr_b), .mem_wdata_o(mem_wdata_b),
        .mem_rdata_i(mem_rdata), .mem_err_i(mem_err), .busy_o(busy_b),
        .perf_instr_gnt_o(perf_i_b), .perf_data_gnt_o(perf_d_b), .perf_stall_o(perf_s_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: queue of outstanding source IDs (0 = instr, 1 = data) plus arbitration state.
    bit          mq[$];
    bit          m_prio, m_lock, m_lsrc;
    int unsigned m_ig, m_dg, m_st;

    function automatic bit m_full();
        return mq.size() >= MAXO;
    endfunction

    function automatic bit m_win();
        if (m_lock) return m_lsrc;
        if (data_req && !instr_req) return 1'b1;
        if (instr_req && !data_req) return 1'b0;
        if (instr_req && data_req) return RR ? m_prio : 1'b1;
        return 1'b0;
    endfunction

    function automatic int unsigned exp_perf(input int unsigned v);
`ifdef ARB_PERF_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input bit we,
                         input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd,
                         input bit g, input bit rv, input logic [31:0] rd, input bit er);
        instr_req = ir; instr_addr = ia; data_req = dr; data_we = we; data_be = be;
        data_addr = da; data_wdata = wd; mem_gnt = g; mem_rvalid = rv; mem_rdata = rd; mem_err = er;
    endtask

    // Advance the model with the current inputs, then move to 1ns after the next rising edge.
    task automatic tick();
        bit req, w, gr;
        req = (instr_req || data_req) && !m_full();
        w   = m_win();
        gr  = req && mem_gnt;
        if (mem_rvalid && mq.size() > 0) void'(mq.pop_front());
        if (gr) begin
            mq.push_back(w);
            m_prio = !w;
            m_lock = 1'b0;
            if (w) m_dg++; else m_ig++;
        end else if (req) begin
            m_lock = 1'b1;
            m_lsrc = w;
        end
        if ((instr_req || data_req) && !gr) m_st++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        mq.delete();
        m_prio = 1'b1; m_lock = 1'b0; m_lsrc = 1'b0;
        m_ig = 0; m_dg = 0; m_st = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({mem_req, instr_gnt, data_gnt, instr_rvalid, data_rvalid, busy} !== 6'b0)
            begin errors++; $display("FAIL reset_ctrl: got %b expected 000000",
                {mem_req, instr_gnt, data_gnt, instr_rvalid, data_rvalid, busy}); end
        checks++;
        if ({perf_i, perf_d, perf_s} !== 96'h0)
            begin errors++; $display("FAIL reset_perf: got %h %h %h expected 0", perf_i, perf_d, perf_s); end
        tick();
    endtask

    task automatic test_single_fetch();
        drive(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr, mem_we, mem_be, instr_gnt, data_gnt} !== {1'b1, 32'h100, 1'b0, 4'hF, 1'b1, 1'b0})
            begin errors++; $display("FAIL fetch_req: got addr=%h we=%b be=%h ig=%b dg=%b",
                mem_addr, mem_we, mem_be, instr_gnt, data_gnt); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
        @(negedge clk);
        checks++;
        if ({instr_rvalid, instr_rdata, data_rvalid} !== {1'b1, 32'hDEADBEEF, 1'b0})
            begin errors++; $display("FAIL fetch_rsp: got irv=%b rdata=%h drv=%b expected 1 deadbeef 0",
                instr_rvalid, instr_rdata, data_rvalid); end
        tick();
    endtask

    task automatic test_round_robin();
        bit exp_d;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h1000 + k, 1, 0, 4'h3, 32'h2000 + k, 0, 1, k > 0, 0, 0);
            @(negedge clk);
            exp_d = (k % 2 == 0);
            checks++;
            if ({data_gnt, instr_gnt} !== {exp_d, !exp_d})
                begin errors++; $display("FAIL rr_order[%0d]: got dg=%b ig=%b expected dg=%b",
                    k, data_gnt, instr_gnt, exp_d); end
            checks++;
            if ({data_gnt_b, instr_gnt_b} !== 2'b10)
                begin errors++; $display("FAIL fixed_order[%0d]: got dg=%b ig=%b expected dg=1 ig=0",
                    k, data_gnt_b, instr_gnt_b); end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        tick();
    endtask

    task automatic test_lock();
        for (int k = 0; k < 5; k++) begin
            drive(k < 4, 32'h200, k > 0, 1, 4'h3, 32'h300, 32'hA5A5, k >= 3, 0, 0, 0);
            @(negedge clk);
            checks++;
            if (k < 4) begin
                if ({mem_addr, mem_we, mem_be, instr_gnt, data_gnt} !== {32'h200, 1'b0, 4'hF, k == 3, 1'b0})
                    begin errors++; $display("FAIL lock_hold[%0d]: got addr=%h we=%b ig=%b dg=%b",
                        k, mem_addr, mem_we, instr_gnt, data_gnt); end
            end else begin
                if ({mem_addr, mem_we, mem_wdata, data_gnt, instr_gnt} !== {32'h300, 1'b1, 32'hA5A5, 1'b1, 1'b0})
                    begin errors++; $display("FAIL lock_next: got addr=%h we=%b wd=%h dg=%b ig=%b",
                        mem_addr, mem_we, mem_wdata, data_gnt, instr_gnt); end
            end
            tick();
        end
        repeat (2) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            @(negedge clk);
            tick();
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h40, k > 0, 0, 4'hF, 32'h80, 0, 1, k == 2, 0, 0);
            @(negedge clk);
            if (k == 2) begin
                checks++;
                if ({mem_req, busy, instr_gnt, data_gnt} !== 4'b0100)
                    begin errors++; $display("FAIL full_block: got req=%b busy=%b ig=%b dg=%b expected 0 1 0 0",
                        mem_req, busy, instr_gnt, data_gnt); end
            end else if (k == 3) begin
                checks++;
                if (mem_req !== 1'b1)
                    begin errors++; $display("FAIL full_release: got req=%b expected 1", mem_req); end
            end
            tick();
        end
        repeat (2) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            @(negedge clk);
            tick();
        end
    endtask

    task automatic test_order_err();
        drive(1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk); tick();
        drive(0, 0, 1, 0, 4'hF, 32'h20, 0, 1, 0, 0, 0);
        @(negedge clk); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1, 0);
        @(negedge clk);
        checks++;
        if ({instr_rvalid, data_rvalid, instr_rdata, instr_err} !== {1'b1, 1'b0, 32'h1, 1'b0})
            begin errors++; $display("FAIL order_instr: got irv=%b drv=%b rdata=%h err=%b expected 1 0 1 0",
                instr_rvalid, data_rvalid, instr_rdata, instr_err); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2, 1);
        @(negedge clk);
        checks++;
        if ({data_rvalid, instr_rvalid, data_rdata, data_err} !== {1'b1, 1'b0, 32'h2, 1'b1})
            begin errors++; $display("FAIL order_data: got drv=%b irv=%b rdata=%h err=%b expected 1 0 2 1",
                data_rvalid, instr_rvalid, data_rdata, data_err); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3, 0);
        @(negedge clk);
        checks++;
        if ({instr_rvalid, data_rvalid, busy} !== 3'b000)
            begin errors++; $display("FAIL spurious_rsp: got irv=%b drv=%b busy=%b expected 000",
                instr_rvalid, data_rvalid, busy); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1, 32'h50, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0)
            begin errors++; $display("FAIL async_reset: got busy=%b expected 0", busy); end
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77, 0);
        @(negedge clk);
        checks++;
        if ({instr_rvalid, data_rvalid} !== 2'b00)
            begin errors++; $display("FAIL post_reset_rsp: got irv=%b drv=%b expected 00",
                instr_rvalid, data_rvalid); end
        tick();
    endtask

    task automatic test_counters();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            drive(k < 4, 32'h600, k >= 4, 0, 4'hF, 32'h700, 0, 1, 0, 0, 0);
            @(negedge clk); tick();
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            @(negedge clk); tick();
        end
        repeat (5) begin
            drive(1, 32'h600, 1, 0, 4'hF, 32'h700, 0, 0, 0, 0, 0);
            @(negedge clk); tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({perf_i, perf_d, perf_s} !== {exp_perf(4), exp_perf(3), exp_perf(5)})
            begin errors++; $display("FAIL perf_count: got %0d %0d %0d expected %0d %0d %0d",
                perf_i, perf_d, perf_s, exp_perf(4), exp_perf(3), exp_perf(5)); end
        tick();
    endtask

    task automatic test_random();
        bit ereq, w, epop, eir, edr;
        int bad;
        bad = 0;
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                  4'($urandom), $urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 2) == 0,
                  $urandom, $urandom_range(0, 1));
            @(negedge clk);
            ereq = (instr_req || data_req) && !m_full();
            w    = m_win();
            epop = mem_rvalid && mq.size() > 0;
            eir  = epop && (mq[0] == 1'b0);
            edr  = epop && (mq[0] == 1'b1);
            checks++;
            if ({mem_req, instr_gnt, data_gnt} !== {ereq, ereq && mem_gnt && !w, ereq && mem_gnt && w})
                begin errors++; bad++; $display("FAIL rand_req[%0d]: got %b expected %b", n,
                    {mem_req, instr_gnt, data_gnt}, {ereq, ereq && mem_gnt && !w, ereq && mem_gnt && w}); end
            checks++;
            if ({instr_rvalid, data_rvalid, busy} !== {eir, edr, mq.size() != 0})
                begin errors++; bad++; $display("FAIL rand_rsp[%0d]: got %b expected %b", n,
                    {instr_rvalid, data_rvalid, busy}, {eir, edr, mq.size() != 0}); end
            if (ereq) begin
                checks++;
                if ({mem_addr, mem_we, mem_be, mem_wdata} !==
                    (w ? {data_addr, data_we, data_be, data_wdata} : {instr_addr, 1'b0, 4'hF, 32'h0}))
                    begin errors++; bad++; $display("FAIL rand_mux[%0d]: got addr=%h we=%b be=%h wd=%h win=%b",
                        n, mem_addr, mem_we, mem_be, mem_wdata, w); end
            end
            if (epop) begin
                checks++;
                if ({instr_rdata, instr_err, data_rdata, data_err} !== {mem_rdata, mem_err, mem_rdata, mem_err})
                    begin errors++; bad++; $display("FAIL rand_rdata[%0d]: got %h/%b %h/%b", n,
                        instr_rdata, instr_err, data_rdata, data_err); end
            end
            tick();
            if (bad > 10) break;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({perf_i, perf_d, perf_s} !== {exp_perf(m_ig), exp_perf(m_dg), exp_perf(m_st)})
            begin errors++; $display("FAIL rand_perf: got %0d %0d %0d expected %0d %0d %0d",
                perf_i, perf_d, perf_s, exp_perf(m_ig), exp_perf(m_dg), exp_perf(m_st)); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_lock();
        test_full();
        test_order_err();
        test_reset_mid();
        test_counters();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
